not_not_answer_checker: RTL and testbench

//  Player-response side of the NotNot round. It latches the 4-bit expected-answer mask

---
 rtl/not_not_answer_checker.sv | 158 +++++++++++++++
 tb/tb_not_not_answer_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/not_not_answer_checker.sv
// NotNot answer checker: latches a round's expected-answer mask, synchronises and
// edge-detects the four player colour inputs, judges the first press (or the lack of
// one at timeout), and keeps score, lives and the game-over flag.
module not_not_answer_checker #(
    parameter int TIMEOUT_CYCLES = 100_000_000,   // answer window in clocks, >= 2
    parameter int SCORE_W        = 8,
    parameter int LIVES          = 3              // 1..3
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               round_start_i,
    input  logic [3:0]         expected_i,
    input  logic [3:0]         player_in_i,
    output logic               busy_o,
    output logic               correct_o,
    output logic               wrong_o,
    output logic               timed_out_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [1:0]         lives_o,
    output logic               game_over_o
);

    localparam int                 TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    // Input path registers
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] rise;

    // Round / game state
    logic [1:0]         state_q, state_d;
    logic [3:0]         exp_q, exp_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               busy_q, busy_d;
    logic               correct_q, correct_d;
    logic               wrong_q, wrong_d;
    logic               timed_out_q, timed_out_d;
    logic               game_over_q, game_over_d;

    // Verdict decode for the current WAIT cycle
    logic one_hot, v_good, v_bad, v_tout;

    // Two-flop synchroniser plus previous-value register for edge detection
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= player_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise    = sync2_q & ~prev_q;
    assign one_hot = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);

    // Judge the round: a press beats the timeout even on the expiry cycle
    always_comb begin
        v_good = 1'b0;
        v_bad  = 1'b0;
        v_tout = 1'b0;
        if (rise != 4'd0) begin
            if (one_hot && ((rise & exp_q) != 4'd0)) v_good = 1'b1;
            else                                      v_bad  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
            if (exp_q == 4'd0) v_good = 1'b1;
            else               v_tout = 1'b1;
        end
    end

    // Next-state logic: round start, verdict bookkeeping, game-over entry
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        timer_d     = timer_q;
        score_d     = score_q;
        lives_d     = lives_q;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        timed_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (round_start_i) begin
                    exp_d   = expected_i;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (v_good) begin
                    correct_d = 1'b1;
                    score_d   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
                    state_d   = S_IDLE;
                end else if (v_bad || v_tout) begin
                    wrong_d     = v_bad;
                    timed_out_d = v_tout;
                    lives_d     = lives_q - 2'd1;
                    state_d     = (lives_q == 2'd1) ? S_OVER : S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d == S_WAIT);
        game_over_d = (state_d == S_OVER);
    end

    // State and registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            exp_q       <= '0;
            timer_q     <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            busy_q      <= 1'b0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            timed_out_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            timer_q     <= timer_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            busy_q      <= busy_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            timed_out_q <= timed_out_d;
            game_over_q <= game_over_d;
        end
    end

    assign busy_o      = busy_q;
    assign correct_o   = correct_q;
    assign wrong_o     = wrong_q;
    assign timed_out_o = timed_out_q;
    assign score_o     = score_q;
    assign lives_o     = lives_q;
    assign game_over_o = game_over_q;

endmodule

// File: tb/tb_not_not_answer_checker.sv
// Bench for the NotNot answer checker: directed scenarios plus random rounds, judged
// against a round-level model (score/lives counters and a verdict rule function).
module tb_not_not_answer_checker;

    localparam int T  = 16;
    localparam int SW = 3;     // small score width so saturation is reachable
    localparam int LV = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          round_start = 1'b0;
    logic [3:0]    expected = 4'd0;
    logic [3:0]    player_in = 4'd0;
    logic          busy, correct, wrong, timed_out, game_over;
    logic [SW-1:0] score;
    logic [1:0]    lives;

    not_not_answer_checker #(.TIMEOUT_CYCLES(T), .SCORE_W(SW), .LIVES(LV)) dut (
        .clock_i(clock), .reset_i(reset), .round_start_i(round_start),
        .expected_i(expected), .player_in_i(player_in),
        .busy_o(busy), .correct_o(correct), .wrong_o(wrong), .timed_out_o(timed_out),
        .score_o(score), .lives_o(lives), .game_over_o(game_over)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int m_score;
    int m_lives;
    bit m_go;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_score"}, 32'(score), 32'(m_score));
        chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; round_start = 1'b0; player_in = 4'd0;
        tick(); tick();
        reset = 1'b0;
        m_score = 0; m_lives = LV; m_go = 1'b0;
        chk({tag, "_flags"}, 32'({game_over, busy, correct, wrong, timed_out}), 32'(0));
        check_totals(tag);
    endtask

    // Verdict rules: 0 correct, 1 wrong, 2 timed out
    function automatic int judge(input logic [3:0] mask, input bit pressed, input logic [3:0] p);
        if (pressed) begin
            if ($countones(p) != 1) return 1;
            return ((p & mask) != 4'd0) ? 0 : 1;
        end
        return (mask == 4'd0) ? 0 : 2;
    endfunction

    // mode: 0 no press, 1 press sampled d edges after the start edge,
    //       2 press held since before round_start, 3 held then released and re-pressed
    // rs_at: offset at which a stray round_start (inverted mask) is injected, -1 for none
    task automatic run_round(input string tag, input logic [3:0] mask, input int mode,
                             input logic [3:0] p, input int d, input int rs_at);
        bit         pressed;
        bit         go0;
        bit         fatal;
        int         v;
        int         lat;
        logic [4:0] e;
        pressed = (mode == 1) || (mode == 3);
        go0     = m_go;
        if (mode >= 2) begin
            player_in = p;
            repeat (4) tick();
        end
        round_start = 1'b1; expected = mask;
        tick();
        round_start = 1'b0; expected = 4'($urandom);
        v     = judge(mask, pressed, p);
        lat   = pressed ? d + 2 : T;
        fatal = !go0 && (v != 0) && (m_lives == 1);
        for (int o = 0; o <= T + 3; o++) begin
            if (go0) e = 5'b10000;
            else begin
                e[4] = fatal && (o >= lat);
                e[3] = (o < lat);
                e[2] = (o == lat) && (v == 0);
                e[1] = (o == lat) && (v == 1);
                e[0] = (o == lat) && (v == 2);
            end
            chk(tag, 32'({game_over, busy, correct, wrong, timed_out}), 32'(e));
            if (o == rs_at) begin round_start = 1'b1; expected = ~mask; end
            else round_start = 1'b0;
            if (mode == 1 && o == d - 1) player_in = p;
            if (mode == 3 && o == d - 2) player_in = 4'd0;
            if (mode == 3 && o == d - 1) player_in = p;
            tick();
        end
        round_start = 1'b0;
        player_in = 4'd0;
        repeat (3) tick();
        if (!go0) begin
            if (v == 0) m_score = (m_score == (1 << SW) - 1) ? m_score : m_score + 1;
            else begin
                m_lives--;
                if (m_lives == 0) m_go = 1'b1;
            end
        end
        check_totals(tag);
    endtask

    initial begin
        logic [3:0] mask, p;
        int         mode, d, lat, rs;

        do_reset("reset");

        // Basic verdicts
        run_round("t1_correct", 4'b0100, 1, 4'b0100, 3, -1);
        run_round("t2_wrong",   4'b0011, 1, 4'b1000, 2, -1);
        run_round("t3_nopress_ok", 4'b0000, 0, 4'b0000, 0, -1);
        run_round("t3_timeout", 4'b1111, 0, 4'b0000, 0, -1);

        // Multi-press and expiry-cycle press
        do_reset("reset_t4");
        run_round("t4_multi",        4'b1111, 1, 4'b0101, 5, -1);
        run_round("t4_expiry_good",  4'b0010, 1, 4'b0010, T - 2, -1);
        run_round("t4_expiry_wrong", 4'b1000, 1, 4'b0100, T - 2, -1);

        // Lives run out, then everything frozen
        do_reset("reset_t5");
        run_round("t5_w1", 4'b0001, 1, 4'b0010, 4, -1);
        run_round("t5_w2", 4'b0001, 1, 4'b0110, 4, -1);
        run_round("t5_w3", 4'b0001, 0, 4'b0000, 0, -1);
        chk("t5_game_over", 32'(game_over), 32'(1));
        run_round("t5_frozen_press", 4'b0001, 1, 4'b0001, 3, -1);
        run_round("t5_frozen_none",  4'b0000, 0, 4'b0000, 0, -1);
        do_reset("t5_reset");

        // Reset mid-round
        run_round("t6_pre", 4'b0010, 1, 4'b0010, 2, -1);
        round_start = 1'b1; expected = 4'b0100;
        tick();
        round_start = 1'b0;
        repeat (7) tick();
        chk("t6_busy_mid", 32'(busy), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_score = 0; m_lives = LV; m_go = 1'b0;
        chk("t6_after_reset", 32'({busy, correct, wrong, timed_out, game_over}), 32'(0));
        check_totals("t6_after_reset");
        for (int i = 0; i < T; i++) begin
            chk("t6_quiet", 32'({busy, correct, wrong, timed_out, game_over}), 32'(0));
            tick();
        end

        // Stray round_start in WAIT keeps the original mask
        run_round("t6_stray_start", 4'b0001, 1, 4'b0001, 6, 2);

        // Held presses: not judged unless released and pressed again
        run_round("held_ignored", 4'b0010, 2, 4'b0010, 0, -1);
        run_round("held_repress", 4'b0010, 3, 4'b0010, 5, -1);

        // Score saturation
        do_reset("reset_sat");
        for (int i = 0; i < 9; i++) run_round("sat", 4'b1001, 1, 4'b1000, 1, -1);
        chk("sat_final", 32'(score), 32'((1 << SW) - 1));

        // Random rounds
        do_reset("reset_rand");
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom);
            mode = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       p = (mask != 4'd0) ? (mask & (~mask + 4'd1)) : 4'd1 << $urandom_range(0, 3);
                1:       p = 4'd1 << $urandom_range(0, 3);
                default: p = 4'($urandom);
            endcase
            if (p == 4'd0) p = 4'b1000;
            d   = (mode == 3) ? $urandom_range(2, T - 2) : $urandom_range(1, T - 2);
            lat = (mode == 1 || mode == 3) ? d + 2 : T;
            rs  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, lat - 1) : -1;
            run_round("rand", mask, mode, p, d, rs);
            if (m_go) do_reset("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
